wide_add_sequencer: RTL and testbench
=====================================

Name: wide_add_sequencer

Overview:
- Multi-cycle controller for wide addition and subtraction.
- Owns one shared N-bit CBPA carry-bypass adder instance and feeds it one N-bit word per cycle, least-significant word first, for a (N*WORDS)-bit operation.
- The carry is chained between words through a register.
- Sits between the ALU issue logic and the adder, trading latency for area on wide arithmetic.

Parameters:
N, 32, adder word width; must be a multiple of 8 and >= 16 (CBPA constraint)
WORDS, 4, number of N-bit words per operand; >= 2

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only when accepting
sub  input  1  0 = A+B, 1 = A-B; sampled with start
a  input  N*WORDS  operand A; sampled with start
b  input  N*WORDS  operand B; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle completion pulse
sum  output  N*WORDS  registered result
cout  output  1  carry out of the MSB word (for sub: 1 = no borrow)
of  output  1  signed overflow of the full-width result

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; busy=0, done=0, sum=0, cout=0, of=0.
  - Word index, carry register and all operand/working registers cleared.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - start=1 captures a, b (b bitwise inverted if sub=1) and sub.
  - Carry register := sub; index := 0; next state ADD.
- ADD, one cycle per word k = 0..WORDS-1:
  - Adder inputs: A word k, B' word k, cin = carry register.
  - Adder S is written into working word k.
  - Carry register := adder cout; index increments.
  - At k = WORDS-1:
    - Working result is copied to sum (including the last word, written the same edge).
    - cout := adder cout; of := adder OF. OF is computed on A and B', so it is correct for subtraction.
    - Next state DONE.
- DONE (1 cycle): done=1.
  - start=1 in this cycle is accepted exactly as in IDLE and goes to ADD (back-to-back).
  - Otherwise return to IDLE.
- busy:
  - 1 in every ADD cycle; 0 in IDLE and DONE.
  - Registered: rises the cycle after start is accepted.
- Latency: start accepted at edge t -> done=1 during cycle t+WORDS+1. Throughput is one operation per WORDS+1 cycles.
- start while in ADD is ignored, with no queuing; the inputs are not re-sampled.
- sum/cout/of:
  - Change only on the final ADD edge and hold until the next completion or reset.
  - Partial results are never visible on sum.
- Reset mid-operation:
  - Aborts immediately; no done pulse; outputs return to reset values.
  - The first start after rst_n rises is accepted normally.
- Width rules: all word slices are [k*N+N-1 : k*N]; index width = clog2(WORDS), minimum 1; no wrap beyond WORDS-1.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, release -> busy=0, done=0, sum=0, cout=0, of=0.
- Carry chain (N=32, WORDS=4): a=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, b=1, sub=0, start at t:
  - sum=0x0000_0000_0000_0000_0000_0001_0000_0000, cout=0, of=0.
  - done exactly at cycle t+5; busy high in cycles t+1..t+4.
- Full wrap: a=all ones, b=1, sub=0 -> sum=0, cout=1, of=0.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000_0000_0000_0000_0000, of=1, cout=0.
- Subtract: a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, cout=0, of=0.
  - Then start again during the DONE cycle with a=7, b=5, sub=1 -> accepted back-to-back; sum=2, cout=1, of=0.
- Protocol:
  - Start pulsed during busy with different operands -> ignored; the result matches the first operands.
  - rst_n driven low at cycle t+2 of an operation -> busy=0, sum=0 immediately, and no done pulse.

Source files
------------

// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide add/subtract controller. One shared N-bit carry-bypass adder
// processes one word per cycle, least-significant word first.

module cbpa_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] s_o,
    output logic         cout_o,
    output logic         of_o
);
    localparam int BLK = 8;
    localparam int NB  = N / BLK;

    logic c_blk;
    logic c_rip;
    logic p_blk;
    logic p_bit;
    logic c_msb;

    // Each 8-bit block ripples internally; a fully propagating block passes
    // its carry-in straight through instead of waiting for the ripple.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        s_o   = '0;
        c_blk = cin_i;
        c_rip = 1'b0;
        p_blk = 1'b0;
        p_bit = 1'b0;
        c_msb = 1'b0;
        for (int blk = 0; blk < NB; blk++) begin
            // NOTE: blocking assignments here model the ripple order within one evaluation.
            c_rip = c_blk;
            p_blk = 1'b1;
            for (int i = 0; i < BLK; i++) begin
                p_bit = a_i[blk*BLK+i] ^ b_i[blk*BLK+i];
                s_o[blk*BLK+i] = p_bit ^ c_rip;
                if (blk*BLK+i == N-1) c_msb = c_rip;
                c_rip = (a_i[blk*BLK+i] & b_i[blk*BLK+i]) | (p_bit & c_rip);
                p_blk = p_blk & p_bit;
            end
            c_blk = p_blk ? c_blk : c_rip;
        end
        cout_o = c_blk;
        of_o   = c_msb ^ c_blk;
    end
endmodule

module wide_add_sequencer #(
    parameter int N     = 32,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sub,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [N*WORDS-1:0] sum,
    output logic               cout,
    output logic               of
);
    localparam int W     = N * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     work_q, work_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             of_q, of_d;

    logic [N-1:0] add_a, add_b, add_s;
    logic         add_cout, add_of;
    logic         accept;

    assign add_a = a_q[idx_q*N +: N];
    assign add_b = b_q[idx_q*N +: N];

    cbpa_adder #(.N(N)) u_adder (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (carry_q),
        .s_o    (add_s),
        .cout_o (add_cout),
        .of_o   (add_of)
    );

    // A new request is taken in IDLE and also in DONE for back-to-back issue.
    assign accept = start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        of_d    = of_q;

        case (state_q)
            ADD: begin
                work_d[idx_q*N +: N] = add_s;
                carry_d = add_cout;
                if (idx_q == LAST) begin
                    sum_d   = work_d;
                    cout_d  = add_cout;
                    of_d    = add_of;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Subtraction is A + ~B + 1: invert B once here and seed the carry with 1.
        if (accept) begin
            state_d = ADD;
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub;
            idx_d   = '0;
        end
    end

    // NOTE: operand and working registers are reset too, so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            of_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            of_q    <= of_d;
        end
    end

    assign busy = (state_q == ADD);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign of   = of_q;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Randomized self-checking bench for wide_add_sequencer against a
// full-width arithmetic reference model.

module tb_wide_add_sequencer;
    localparam int N     = 32;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, of;
    logic [W-1:0] sum;

    int tests = 0;
    int fails = 0;

    wide_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .of    (of)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full-width reference: two's-complement add/subtract on 129-bit numbers.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                         output logic [W-1:0] s, output logic c, output logic o);
        logic [W:0] full;
        if (msub) full = {1'b0, ma} - {1'b0, mb};
        else      full = {1'b0, ma} + {1'b0, mb};
        s = full[W-1:0];
        // For subtraction, carry-out means "no borrow": a >= b unsigned.
        c = msub ? (ma >= mb) : full[W];
        if (msub) o = (ma[W-1] != mb[W-1]) && (s[W-1] != ma[W-1]);
        else      o = (ma[W-1] == mb[W-1]) && (s[W-1] != ma[W-1]);
    endtask

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v;
        for (int i = 0; i < W/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Called just after a clock edge while the DUT is in IDLE or DONE; returns
    // just after the edge that enters DONE, so a following call is back-to-back.
    task automatic run_op(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic op_sub, input bit inject);
        logic [W-1:0] es, prev_sum;
        logic         ec, eo;
        model(op_a, op_b, op_sub, es, ec, eo);
        prev_sum = sum;
        start = 1'b1; a = op_a; b = op_b; sub = op_sub;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 1; j <= WORDS + 1; j++) begin
            if (j > 1) begin
                @(posedge clk); #1;
            end
            check({tag, "_busy"}, (W+1)'(busy), (W+1)'(j <= WORDS));
            check({tag, "_done"}, (W+1)'(done), (W+1)'(j == WORDS + 1));
            if (j <= WORDS) check({tag, "_sum_hold"}, (W+1)'(sum), (W+1)'(prev_sum));
            if (inject && j == 2) begin
                start = 1'b1; a = rand_wide(); b = rand_wide(); sub = ~op_sub;
            end
            if (inject && j == 3) start = 1'b0;
        end
        check({tag, "_sum"},  (W+1)'(sum),  (W+1)'(es));
        check({tag, "_cout"}, (W+1)'(cout), (W+1)'(ec));
        check({tag, "_of"},   (W+1)'(of),   (W+1)'(eo));
    endtask

    task automatic idle_gap();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] v;
        ones = '1;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", (W+1)'(busy), '0);
        check("rst_done", (W+1)'(done), '0);
        check("rst_sum",  (W+1)'(sum),  '0);
        check("rst_cout", (W+1)'(cout), '0);
        check("rst_of",   (W+1)'(of),   '0);

        run_op("chain", W'(64'hFFFF_FFFF), W'(1), 1'b0, 1'b0);
        check("chain_val", (W+1)'(sum), (W+1)'(64'h1_0000_0000));
        idle_gap();
        run_op("wrap", ones, W'(1), 1'b0, 1'b0);
        idle_gap();
        v = {1'b0, {(W-1){1'b1}}};
        run_op("ovf", v, W'(1), 1'b0, 1'b0);
        check("ovf_of_set", (W+1)'(of), (W+1)'(1));
        idle_gap();
        run_op("sub57", W'(5), W'(7), 1'b1, 1'b0);
        run_op("sub75_b2b", W'(7), W'(5), 1'b1, 1'b0);
        check("sub75_val", (W+1)'(sum), (W+1)'(2));
        idle_gap();
        run_op("ignore", rand_wide(), rand_wide(), 1'b0, 1'b1);
        idle_gap();

        for (int i = 0; i < 24; i++) begin
            run_op("rand", rand_wide(), rand_wide(), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 0) idle_gap();
        end

        // Abort mid-operation: outputs clear at once and no done pulse follows.
        start = 1'b1; a = ones; b = W'(1); sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", (W+1)'(busy), '0);
        check("abort_done", (W+1)'(done), '0);
        check("abort_sum",  (W+1)'(sum),  '0);
        check("abort_cout", (W+1)'(cout), '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int j = 0; j < WORDS + 2; j++) begin
            @(posedge clk); #1;
            check("abort_no_done", (W+1)'(done), '0);
        end
        run_op("after_rst", W'(5), W'(7), 1'b1, 1'b0);
        idle_gap();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
